// File: rtl/mem_wb_stage.sv
// Memory-access / writeback stage: byte/half/word loads and stores on a local
// data memory, then the registered register-file write port for decode.
module mem_wb_stage #(
  parameter int DMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_m,
  input  logic        regwrite_m,
  input  logic [1:0]  result_src_m,
  input  logic        memwrite_m,
  input  logic [2:0]  funct3_m,
  input  logic [31:0] alu_result_m,
  input  logic [31:0] write_data_m,
  input  logic [4:0]  rd_m,
  input  logic [31:0] pc_plus_4_m,
  output logic        writeback_control,
  output logic [4:0]  rd,
  output logic [31:0] writeback_data,
  output logic        access_err
);

  localparam int AW = $clog2(DMEM_WORDS);

  logic [31:0]   dmem_r [DMEM_WORDS];
  logic [AW-1:0] widx_s;
  logic [1:0]    offset_s;
  logic [31:0]   word_s;
  logic [7:0]    byte_s;
  logic [15:0]   half_s;
  logic [31:0]   load_data_s;
  logic [31:0]   st_word_s;
  logic [31:0]   wb_mux_s;
  logic          load_ok_s;
  logic          store_ok_s;
  logic          legal_s;
  logic          mem_we_s;
  logic          unused_addr_s;

  // Upper address bits beyond the memory are ignored, so accesses wrap.
  assign widx_s        = alu_result_m[AW+1:2];
  assign offset_s      = alu_result_m[1:0];
  assign unused_addr_s = ^alu_result_m[31:AW+2];
  assign word_s        = dmem_r[widx_s];

  // Alignment and encoding legality for loads and stores.
  always_comb begin
    load_ok_s  = 1'b0;
    store_ok_s = 1'b0;
    case (funct3_m)
      3'b000:  begin load_ok_s = 1'b1;            store_ok_s = 1'b1;            end
      3'b001:  begin load_ok_s = ~offset_s[0];    store_ok_s = ~offset_s[0];    end
      3'b010:  begin load_ok_s = offset_s == 2'b00; store_ok_s = offset_s == 2'b00; end
      3'b100:  begin load_ok_s = 1'b1;            store_ok_s = 1'b0;            end
      3'b101:  begin load_ok_s = ~offset_s[0];    store_ok_s = 1'b0;            end
      default: begin load_ok_s = 1'b0;            store_ok_s = 1'b0;            end
    endcase
    legal_s = 1'b1;
    if (result_src_m == 2'b01) begin
      legal_s = load_ok_s;
    end else if (memwrite_m) begin
      legal_s = store_ok_s;
    end else begin
      legal_s = 1'b1;
    end
  end

  assign mem_we_s = valid_m & memwrite_m & legal_s;

  // Lane extraction and sign/zero extension of load data.
  always_comb begin
    case (offset_s)
      2'b00:   byte_s = word_s[7:0];
      2'b01:   byte_s = word_s[15:8];
      2'b10:   byte_s = word_s[23:16];
      2'b11:   byte_s = word_s[31:24];
      default: byte_s = word_s[7:0];
    endcase
    if (offset_s[1]) begin
      half_s = word_s[31:16];
    end else begin
      half_s = word_s[15:0];
    end
    case (funct3_m)
      3'b000:  load_data_s = {{24{byte_s[7]}}, byte_s};
      3'b001:  load_data_s = {{16{half_s[15]}}, half_s};
      3'b100:  load_data_s = {24'd0, byte_s};
      3'b101:  load_data_s = {16'd0, half_s};
      default: load_data_s = word_s;
    endcase
  end

  // Merge store data into the addressed word; unwritten lanes keep their value.
  always_comb begin
    st_word_s = word_s;
    case (funct3_m)
      3'b000: begin
        case (offset_s)
          2'b00:   st_word_s[7:0]   = write_data_m[7:0];
          2'b01:   st_word_s[15:8]  = write_data_m[7:0];
          2'b10:   st_word_s[23:16] = write_data_m[7:0];
          2'b11:   st_word_s[31:24] = write_data_m[7:0];
          default: st_word_s        = word_s;
        endcase
      end
      3'b001: begin
        if (offset_s[1]) begin
          st_word_s[31:16] = write_data_m[15:0];
        end else begin
          st_word_s[15:0] = write_data_m[15:0];
        end
      end
      3'b010:  st_word_s = write_data_m;
      default: st_word_s = word_s;
    endcase
  end

  // Writeback source select.
  always_comb begin
    case (result_src_m)
      2'b01:   wb_mux_s = load_data_s;
      2'b10:   wb_mux_s = pc_plus_4_m;
      default: wb_mux_s = alu_result_m;
    endcase
  end

  // Data memory; reset clears every word and aborts any in-flight store.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DMEM_WORDS; i++) begin
        dmem_r[i] <= 32'd0;
      end
    end else if (mem_we_s) begin
      dmem_r[widx_s] <= st_word_s;
    end
  end

  // MEM/WB register; x0 is never written since decode does not guard it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      writeback_control <= 1'b0;
      rd                <= 5'd0;
      writeback_data    <= 32'd0;
      access_err        <= 1'b0;
    end else begin
      writeback_control <= valid_m & regwrite_m & (rd_m != 5'd0) & legal_s;
      rd                <= rd_m;
      writeback_data    <= wb_mux_s;
      access_err        <= valid_m & ~legal_s;
    end
  end

endmodule
